// File: rtl/uart_mmio_pkg.sv
// Shared constants for the UART MMIO front-end: register offsets and
// STATUS/CTRL bit positions.
package uart_mmio_pkg;

    localparam logic [2:0] UART_DATA_OFS = 3'h0;
    localparam logic [2:0] UART_STAT_OFS = 3'h4;

    localparam int unsigned STAT_RXDP    = 0;
    localparam int unsigned STAT_TXFULL  = 1;
    localparam int unsigned STAT_TXEMPTY = 2;
    localparam int unsigned STAT_RXOVR   = 3;
    localparam int unsigned STAT_TXOVF   = 4;

    localparam int unsigned CTRL_TXFLUSH = 0;
    localparam int unsigned CTRL_RXFLUSH = 1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush. Accepts a push while
// full if a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Gate the head so stale storage never leaks out after reset or flush.
    assign dout    = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/uart_mmio_fifo.sv
// UART register front-end: address decode, sticky error flags and the read
// mux around a TX and an RX FIFO.
module uart_mmio_fifo
    import uart_mmio_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_wen,
    input  logic              rx_ren,
    input  logic [2:0]        uart_addr,
    input  logic [DATA_W-1:0] uart_din,
    output logic [DATA_W-1:0] uart_dout,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_irq
);

    localparam int unsigned TX_CNT_W = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH) + 1;

    logic                data_sel, stat_sel;
    logic                tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic                rx_pop, rx_flush, rx_full, rx_empty;
    logic [DATA_W-1:0]   rx_head, status;
    logic [TX_CNT_W-1:0] tx_count;
    logic [RX_CNT_W-1:0] rx_count;
    logic                tx_ovf_evt, rx_ovr_evt, stat_clr;
    logic                tx_overflow_q, tx_overflow_d;
    logic                rx_overrun_q, rx_overrun_d;

    assign data_sel = (uart_addr == UART_DATA_OFS);
    assign stat_sel = (uart_addr == UART_STAT_OFS);

    assign tx_push  = tx_wen & data_sel;
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_flush = tx_wen & stat_sel & uart_din[CTRL_TXFLUSH];
    assign rx_pop   = rx_ren & data_sel;
    assign rx_flush = tx_wen & stat_sel & uart_din[CTRL_RXFLUSH];

    assign tx_valid = ~tx_empty;
    assign rx_irq   = ~rx_empty;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (tx_flush),
        .push  (tx_push),
        .din   (uart_din),
        .pop   (tx_pop),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (rx_flush),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // A drop only happens when the FIFO is full and nothing leaves on this edge.
    assign tx_ovf_evt = tx_push & tx_full & ~tx_pop;
    assign rx_ovr_evt = rx_valid & rx_full & ~rx_pop;
    assign stat_clr   = rx_ren & stat_sel;

    always_comb begin
        tx_overflow_d = tx_overflow_q;
        rx_overrun_d  = rx_overrun_q;
        if (stat_clr) begin
            tx_overflow_d = 1'b0;
            rx_overrun_d  = 1'b0;
        end
        if (tx_ovf_evt) tx_overflow_d = 1'b1;
        if (rx_ovr_evt) rx_overrun_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            tx_overflow_q <= tx_overflow_d;
            rx_overrun_q  <= rx_overrun_d;
        end
    end

    always_comb begin
        status               = '0;
        status[STAT_RXDP]    = ~rx_empty;
        status[STAT_TXFULL]  = tx_full;
        status[STAT_TXEMPTY] = tx_empty;
        status[STAT_RXOVR]   = rx_overrun_q;
        status[STAT_TXOVF]   = tx_overflow_q;
    end

    always_comb begin
        uart_dout = '0;
        if (rx_ren) begin
            if (data_sel)      uart_dout = rx_head;
            else if (stat_sel) uart_dout = status;
        end
    end

    a_no_dual_access: assert property (@(posedge clk) disable iff (rst) !(tx_wen && rx_ren));
    a_tx_count_range: assert property (@(posedge clk) disable iff (rst)
                                       tx_count <= TX_CNT_W'(TX_DEPTH));
    a_rx_count_range: assert property (@(posedge clk) disable iff (rst)
                                       rx_count <= RX_CNT_W'(RX_DEPTH));

endmodule
